rcc_clkdiv_ctrl: RTL
====================

# rcc_clkdiv_ctrl

Control stage directly upstream of the RCC integer clock divider. Owns the divider's ratio register and accepts new ratios from the RCC register file over a valid/ready handshake. It applies each change only at a divided-clock low phase, holds the divider in reset across the change, and reports when the new clock has settled. The divided clock is fed back so that updates are aligned to it.

## Interface
- `WIDTH`, default 6, width of the ratio field; must match the divider's ratio width.
- `RESET_RATIO`, default 2, value of `DIV_RATIO` after reset.
- `SETTLE_PERIODS`, default 2, number of divided-clock periods to wait after release before asserting stable; range 1..15.
- `REF_CLK`  in  1  source clock; all logic on its rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `REQ_VALID`  in  1  a new ratio is offered.
- `REQ_RATIO`  in  WIDTH  requested ratio. 0 and 1 mean bypass; values of 2 or more divide.
- `REQ_READY`  out  1  controller can accept a request.
- `DIV_CLK_IN`  in  1  divider output clock, fed back.
- `DIV_RATIO`  out  WIDTH  registered ratio driven to the divider.
- `DIV_RST_N`  out  1  active-low reset to the divider; the integrator ANDs it with `RST`.
- `CLK_STABLE`  out  1  divided clock is valid at the current `DIV_RATIO`.
- `BUSY`  out  1  a change is in progress.
- `ERR`  out  1  one-cycle pulse when a request is rejected.

## Operation
- Reset values:
  - `DIV_RATIO`=`RESET_RATIO`, `DIV_RST_N`=0, `CLK_STABLE`=0.
  - `REQ_READY`=0, `BUSY`=1, `ERR`=0.
  - State is HOLD with the hold counter cleared, so the controller performs a normal HOLD→SETTLE bring-up after reset.
- States: IDLE, SYNC, HOLD, SETTLE.
- IDLE:
  - `REQ_READY`=1, `BUSY`=0.
  - A transfer occurs on a rising edge with `REQ_VALID`&`REQ_READY`. The ratio is captured into a pending register.
  - If the current `DIV_RATIO` is 0 or 1 (bypass), go to HOLD. Otherwise go to SYNC.
  - A request equal to the current ratio still runs the full sequence.
- SYNC:
  - `DIV_CLK_IN` is registered each cycle. A falling edge is a registered value of 1 followed by a sampled value of 0; on it, go to HOLD.
  - Timeout: if no falling edge arrives within 2^(WIDTH+1) cycles of entry, go to HOLD anyway.
- HOLD:
  - Lasts exactly 2 cycles with `DIV_RST_N`=0 and `CLK_STABLE`=0.
  - `DIV_RATIO` loads the pending ratio on the entry edge.
- SETTLE:
  - `DIV_RST_N`=1. A counter runs for N = `SETTLE_PERIODS`×E cycles, then `CLK_STABLE`=1 and the state returns to IDLE.
  - E = {`DIV_RATIO`[WIDTH-1:1],0} if `DIV_RATIO`≥2, else E=1.
  - The counter width covers 15×(2^WIDTH−2).
- `CLK_STABLE` drops on the cycle the state leaves IDLE toward SYNC. In the bypass path it drops on HOLD entry.
- `REQ_VALID` outside IDLE is ignored; `REQ_READY`=0 there. The requester must hold `REQ_VALID` until it sees `REQ_READY`.
- Asserting `RST` in any state returns every output to its reset value asynchronously. The pending ratio is discarded.

## Timing
- Request accepted at edge T.
  - Divide path: SYNC from T+1. Falling edge detected at edge S gives HOLD at S+1, `DIV_RATIO` new at S+1, `DIV_RST_N` high at S+3, `CLK_STABLE`/`REQ_READY` high at S+3+N.
  - Bypass path: HOLD at T+1, `DIV_RST_N` high at T+3, stable at T+3+N.
- After reset release at edge R: `DIV_RST_N` high at R+2, `CLK_STABLE` high at R+2+N(`RESET_RATIO`).
- `ERR` is registered: high for exactly the cycle after the rejecting edge.
- The feedback sample adds 1 cycle of latency to edge detection.

## Configuration
- `RCC_DIVCTRL_STRICT_EN`
  - Defined: an odd `REQ_RATIO` ≥3 is rejected. `ERR`=1 at T+1, state stays IDLE, and `DIV_RATIO`, `CLK_STABLE` and `REQ_READY` are unchanged.
  - Undefined: odd ratios are accepted and written unchanged. The divider uses the even part, and settle uses E as defined.

## Test plan
- Reset bring-up, defaults: `RST` low 5 cycles then high → `DIV_RST_N`=0 for 2 cycles, then 1; `CLK_STABLE`=1 exactly 4 cycles later (N=2×2); `REQ_READY`=1.
- Change from ratio 2 to 8:
  - `REQ_RATIO`=8 accepted → HOLD within ≤3 cycles of acceptance, aligned to a `DIV_CLK_IN` falling edge.
  - `DIV_RATIO`=8 at HOLD entry; `CLK_STABLE` asserted 18 cycles after HOLD entry (2 hold + 16 settle).
- Bypass:
  - 8 → 1: path goes through SYNC; settle N=2.
  - Then 1 → 6: SYNC is skipped, HOLD follows the acceptance edge, and `CLK_STABLE` asserts 12 cycles after `DIV_RST_N` rises.
- Odd ratio 5:
  - With `RCC_DIVCTRL_STRICT_EN`: `ERR` pulses 1 cycle and `DIV_RATIO` stays 8.
  - Without it: `DIV_RATIO`=5 and settle is 8 cycles.
- Request held during BUSY: `REQ_VALID`=1 with ratio 4 throughout a change → not accepted until `REQ_READY` returns, then taken on the first IDLE cycle.
- Edge cases:
  - `DIV_CLK_IN` tied 0 in SYNC → HOLD after 128 cycles (WIDTH=6).
  - `RST` pulsed mid-SETTLE → immediate `DIV_RATIO`=2, `CLK_STABLE`=0, `DIV_RST_N`=0.

Source files
------------

// File: rtl/rcc_clkdiv_ctrl.sv
`timescale 1ns/1ps
// rcc_clkdiv_ctrl: owns the RCC divider ratio and sequences ratio changes (sync, hold, settle).
// Build macro RCC_DIVCTRL_STRICT_EN: when defined, odd ratios >= 3 are rejected with a one-cycle ERR pulse.
module rcc_clkdiv_ctrl #(
    parameter int WIDTH          = 6,
    parameter int RESET_RATIO    = 2,
    parameter int SETTLE_PERIODS = 2
) (
    input  logic             REF_CLK,
    input  logic             RST,
    input  logic             REQ_VALID,
    input  logic [WIDTH-1:0] REQ_RATIO,
    output logic             REQ_READY,
    input  logic             DIV_CLK_IN,
    output logic [WIDTH-1:0] DIV_RATIO,
    output logic             DIV_RST_N,
    output logic             CLK_STABLE,
    output logic             BUSY,
    output logic             ERR
);

    localparam int SETTLE_W = $clog2(15 * ((2 ** WIDTH) - 2) + 1);
    localparam int SYNC_W   = WIDTH + 1;

    localparam logic [WIDTH-1:0]    RESET_RATIO_C = WIDTH'(RESET_RATIO);
    localparam logic [WIDTH-1:0]    RATIO_TWO     = WIDTH'(2);
    localparam logic [SETTLE_W-1:0] PERIODS_C     = SETTLE_W'(SETTLE_PERIODS);
    localparam logic [SETTLE_W-1:0] ONE_SETTLE    = SETTLE_W'(1);
    localparam logic [SETTLE_W-1:0] ZERO_SETTLE   = {SETTLE_W{1'b0}};
    localparam logic [SYNC_W-1:0]   SYNC_LAST     = {SYNC_W{1'b1}};
    localparam logic [SYNC_W-1:0]   ZERO_SYNC     = {SYNC_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    // Settle length in REF_CLK cycles: periods times the even part of the ratio (bypass counts as 1).
    function automatic logic [SETTLE_W-1:0] settle_len(input logic [WIDTH-1:0] ratio);
        logic [SETTLE_W-1:0] even_s;
        if (ratio >= RATIO_TWO) begin
            even_s = SETTLE_W'({ratio[WIDTH-1:1], 1'b0});
        end else begin
            even_s = ONE_SETTLE;
        end
        settle_len = PERIODS_C * even_s;
    endfunction

`ifdef RCC_DIVCTRL_STRICT_EN
    function automatic logic odd_divide(input logic [WIDTH-1:0] ratio);
        odd_divide = ratio[0] && (ratio > RATIO_TWO);
    endfunction
`endif

    state_t              state_r,      state_s;
    logic [WIDTH-1:0]    div_ratio_r,  div_ratio_s;
    logic [WIDTH-1:0]    pend_ratio_r, pend_ratio_s;
    logic                hold_cnt_r,   hold_cnt_s;
    logic [SYNC_W-1:0]   sync_cnt_r,   sync_cnt_s;
    logic [SETTLE_W-1:0] settle_cnt_r, settle_cnt_s;
    logic                div_rst_n_r,  div_rst_n_s;
    logic                clk_stable_r, clk_stable_s;
    logic                req_ready_r,  req_ready_s;
    logic                busy_r,       busy_s;
    logic                err_r,        err_s;
    logic                div_clk_q_r;
    logic                div_fall_s;
    logic                reject_s;
    logic [SETTLE_W-1:0] settle_last_s;

`ifdef RCC_DIVCTRL_STRICT_EN
    assign reject_s = odd_divide(REQ_RATIO);
`else
    assign reject_s = 1'b0;
`endif

    assign div_fall_s    = div_clk_q_r && !DIV_CLK_IN;
    assign settle_last_s = settle_len(div_ratio_r) - ONE_SETTLE;

    // Next-state and next-output decode for the ratio change sequencer.
    always_comb begin
        state_s      = state_r;
        div_ratio_s  = div_ratio_r;
        pend_ratio_s = pend_ratio_r;
        hold_cnt_s   = hold_cnt_r;
        sync_cnt_s   = sync_cnt_r;
        settle_cnt_s = settle_cnt_r;
        div_rst_n_s  = div_rst_n_r;
        clk_stable_s = clk_stable_r;
        req_ready_s  = req_ready_r;
        busy_s       = busy_r;
        err_s        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (REQ_VALID && req_ready_r) begin
                    if (reject_s) begin
                        err_s = 1'b1;
                    end else begin
                        pend_ratio_s = REQ_RATIO;
                        clk_stable_s = 1'b0;
                        req_ready_s  = 1'b0;
                        busy_s       = 1'b1;
                        // A bypassed divider has no divided edge to align to, so go straight to HOLD.
                        if (div_ratio_r >= RATIO_TWO) begin
                            state_s    = ST_SYNC;
                            sync_cnt_s = ZERO_SYNC;
                        end else begin
                            state_s     = ST_HOLD;
                            hold_cnt_s  = 1'b0;
                            div_ratio_s = REQ_RATIO;
                            div_rst_n_s = 1'b0;
                        end
                    end
                end else begin
                    req_ready_s = 1'b1;
                    busy_s      = 1'b0;
                end
            end
            ST_SYNC: begin
                if (div_fall_s || (sync_cnt_r == SYNC_LAST)) begin
                    state_s     = ST_HOLD;
                    hold_cnt_s  = 1'b0;
                    div_ratio_s = pend_ratio_r;
                    div_rst_n_s = 1'b0;
                end else begin
                    sync_cnt_s = sync_cnt_r + SYNC_W'(1);
                end
            end
            ST_HOLD: begin
                if (hold_cnt_r) begin
                    state_s      = ST_SETTLE;
                    settle_cnt_s = ZERO_SETTLE;
                    div_rst_n_s  = 1'b1;
                end else begin
                    hold_cnt_s = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_r == settle_last_s) begin
                    state_s      = ST_IDLE;
                    clk_stable_s = 1'b1;
                    req_ready_s  = 1'b1;
                    busy_s       = 1'b0;
                end else begin
                    settle_cnt_s = settle_cnt_r + ONE_SETTLE;
                end
            end
            default: begin
                state_s      = ST_HOLD;
                hold_cnt_s   = 1'b0;
                div_rst_n_s  = 1'b0;
                clk_stable_s = 1'b0;
                req_ready_s  = 1'b0;
                busy_s       = 1'b1;
            end
        endcase
    end

    // Sequencer state and registered outputs; reset restarts a HOLD->SETTLE bring-up and drops any pending ratio.
    always_ff @(posedge REF_CLK or negedge RST) begin
        if (!RST) begin
            state_r      <= ST_HOLD;
            div_ratio_r  <= RESET_RATIO_C;
            pend_ratio_r <= RESET_RATIO_C;
            hold_cnt_r   <= 1'b0;
            sync_cnt_r   <= ZERO_SYNC;
            settle_cnt_r <= ZERO_SETTLE;
            div_rst_n_r  <= 1'b0;
            clk_stable_r <= 1'b0;
            req_ready_r  <= 1'b0;
            busy_r       <= 1'b1;
            err_r        <= 1'b0;
            div_clk_q_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            div_ratio_r  <= div_ratio_s;
            pend_ratio_r <= pend_ratio_s;
            hold_cnt_r   <= hold_cnt_s;
            sync_cnt_r   <= sync_cnt_s;
            settle_cnt_r <= settle_cnt_s;
            div_rst_n_r  <= div_rst_n_s;
            clk_stable_r <= clk_stable_s;
            req_ready_r  <= req_ready_s;
            busy_r       <= busy_s;
            err_r        <= err_s;
            div_clk_q_r  <= DIV_CLK_IN;
        end
    end

    assign DIV_RATIO  = div_ratio_r;
    assign DIV_RST_N  = div_rst_n_r;
    assign CLK_STABLE = clk_stable_r;
    assign REQ_READY  = req_ready_r;
    assign BUSY       = busy_r;
    assign ERR        = err_r;

endmodule
